micro_alpha_veryl_shift_sequencer: RTL and testbench

Multi-bit shift/rotate controller for the single-bit micro1 shifter. It accepts a request (operation, operand, count) and drives the shifter once per cycle for `count` cycles. It selects the shifter operation and carry-in on every step, then returns the 16-bit result and final carry. It sits between instruction control and the shifter datapath, and lets the ISA implement SLL/SRL/SLA/SRA/ROL/ROR by N without a barrel shifter.

---
 rtl/micro_alpha_veryl_shift_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_micro_alpha_veryl_shift_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_alpha_veryl_shift_sequencer.sv
// -----------------------------------------------------------------------------
// micro_alpha_veryl_shift_sequencer
//
// Multi-bit shift/rotate controller wrapped around the single-bit micro1
// shifter. A request (op, operand, count) is accepted in IDLE. The sequencer
// then drives the external shifter for `count` cycles, feeding its own working
// register back through the shifter on every step. The final word and the
// last bit shifted out are returned through a valid/ready response port.
// SLL/SRL/SLA/SRA/ROL/ROR by N therefore need no barrel shifter.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   req_valid/ready   request handshake
//   req_op            0=SLL 1=SRL 2=SLA 3=SRA 4=ROL 5=ROR (6,7 reserved -> NOP)
//   req_operand       16-bit word to shift
//   req_count         number of single-bit steps (0..2^COUNT_WIDTH-1)
//   resp_valid/ready  response handshake
//   resp_result       shifted word (registered)
//   resp_carry        last bit shifted out (registered)
//   busy              high while in SHIFT or DONE
//   sh_operation      operation for the shifter (NOP outside SHIFT)
//   sh_in             shifter input, always the working register
//   sh_cin            shifter carry-in
//   sh_out, sh_cout   shifter result and carry-out
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a request; latches op/operand/count on req_valid
// SHIFT | one shifter step per cycle until the remaining count runs out
// DONE  | result held on resp_*; returns to IDLE once resp_ready is seen
// -----------------------------------------------------------------------------

package micro_alpha_veryl_shift_sequencer_pkg;

  typedef enum logic [2:0] {
    SHIFTER_OPERATION_NOP                  = 3'd0,
    SHIFTER_OPERATION_LEFT_LOGICALLY       = 3'd1,
    SHIFTER_OPERATION_LEFT_ARITHMETICALLY  = 3'd2,
    SHIFTER_OPERATION_RIGHT_LOGICALLY      = 3'd3,
    SHIFTER_OPERATION_RIGHT_ARITHMETICALLY = 3'd4
  } shifter_operation_t;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SLA = 3'd2;
  localparam logic [2:0] OP_SRA = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd4;
  localparam logic [2:0] OP_ROR = 3'd5;

endpackage

module micro_alpha_veryl_shift_sequencer
  import micro_alpha_veryl_shift_sequencer_pkg::*;
#(
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_op,
  input  logic [15:0]            req_operand,
  input  logic [COUNT_WIDTH-1:0] req_count,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [15:0]            resp_result,
  output logic                   resp_carry,
  output logic                   busy,
  output shifter_operation_t     sh_operation,
  output logic [15:0]            sh_in,
  output logic                   sh_cin,
  input  logic [15:0]            sh_out,
  input  logic                   sh_cout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             op_q, op_d;
  logic [15:0]            work_q, work_d;
  logic                   carry_q, carry_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;

  // Reserved opcodes behave as a zero-step NOP: the operand comes straight
  // back with carry 0.
  logic                   req_reserved;
  logic [COUNT_WIDTH-1:0] req_count_eff;

  assign req_reserved  = (req_op > OP_ROR);
  assign req_count_eff = req_reserved ? '0 : req_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_SLL;
      work_q      <= '0;
      carry_q     <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      work_q      <= work_d;
      carry_q     <= carry_d;
      remaining_q <= remaining_d;
    end
  end

  // Operation and carry-in presented to the shifter for the latched op.
  // Rotates recirculate the bit about to fall off the end as carry-in.
  shifter_operation_t step_op;
  logic               step_cin;

  always_comb begin
    step_op  = SHIFTER_OPERATION_NOP;
    step_cin = 1'b0;
    case (op_q)
      OP_SLL: step_op = SHIFTER_OPERATION_LEFT_LOGICALLY;
      OP_SLA: step_op = SHIFTER_OPERATION_LEFT_ARITHMETICALLY;
      OP_SRL: step_op = SHIFTER_OPERATION_RIGHT_LOGICALLY;
      OP_SRA: step_op = SHIFTER_OPERATION_RIGHT_ARITHMETICALLY;
      OP_ROL: begin
        step_op  = SHIFTER_OPERATION_LEFT_LOGICALLY;
        step_cin = work_q[15];
      end
      OP_ROR: begin
        step_op  = SHIFTER_OPERATION_RIGHT_LOGICALLY;
        step_cin = work_q[0];
      end
      default: begin
        step_op  = SHIFTER_OPERATION_NOP;
        step_cin = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    work_d       = work_q;
    carry_d      = carry_q;
    remaining_d  = remaining_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    sh_operation = SHIFTER_OPERATION_NOP;
    sh_cin       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d        = req_op;
          work_d      = req_operand;
          carry_d     = 1'b0;
          remaining_d = req_count_eff;
          state_d     = (req_count_eff != '0) ? ST_SHIFT : ST_DONE;
        end
      end

      ST_SHIFT: begin
        sh_operation = step_op;
        sh_cin       = step_cin;
        work_d       = sh_out;
        carry_d      = sh_cout;
        remaining_d  = remaining_q - COUNT_WIDTH'(1);
        // The step happening on this edge is the last one.
        if (remaining_q == COUNT_WIDTH'(1)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign sh_in       = work_q;
  assign resp_result = work_q;
  assign resp_carry  = carry_q;
  assign busy        = (state_q == ST_SHIFT) || (state_q == ST_DONE);

endmodule

// File: tb/tb_micro_alpha_veryl_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_micro_alpha_veryl_shift_sequencer
//
// Bench for the shift sequencer. A combinational shifter model sits on the
// sh_* port. Results are predicted with whole-word arithmetic (shift and
// rotate operators on integers), not by stepping bit by bit. Inputs are driven
// and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------

module tb_micro_alpha_veryl_shift_sequencer;
  import micro_alpha_veryl_shift_sequencer_pkg::*;

  localparam int CW = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [2:0]         req_op = 3'd0;
  logic [15:0]        req_operand = 16'h0;
  logic [CW-1:0]      req_count = '0;
  logic               resp_valid;
  logic               resp_ready = 1'b0;
  logic [15:0]        resp_result;
  logic               resp_carry;
  logic               busy;
  shifter_operation_t sh_operation;
  logic [15:0]        sh_in;
  logic               sh_cin;
  logic [15:0]        sh_out;
  logic               sh_cout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  micro_alpha_veryl_shift_sequencer #(.COUNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_operand  (req_operand),
    .req_count    (req_count),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_result  (resp_result),
    .resp_carry   (resp_carry),
    .busy         (busy),
    .sh_operation (sh_operation),
    .sh_in        (sh_in),
    .sh_cin       (sh_cin),
    .sh_out       (sh_out),
    .sh_cout      (sh_cout)
  );

  // Single-bit shifter datapath.
  always_comb begin
    sh_out  = sh_in;
    sh_cout = 1'b0;
    case (sh_operation)
      SHIFTER_OPERATION_LEFT_LOGICALLY,
      SHIFTER_OPERATION_LEFT_ARITHMETICALLY: begin
        sh_out  = {sh_in[14:0], sh_cin};
        sh_cout = sh_in[15];
      end
      SHIFTER_OPERATION_RIGHT_LOGICALLY: begin
        sh_out  = {sh_cin, sh_in[15:1]};
        sh_cout = sh_in[0];
      end
      SHIFTER_OPERATION_RIGHT_ARITHMETICALLY: begin
        sh_out  = {sh_in[15], sh_in[15:1]};
        sh_cout = sh_in[0];
      end
      default: begin
        sh_out  = sh_in;
        sh_cout = 1'b0;
      end
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: result, final carry and number of shifter steps.
  function automatic void ref_model(input int op, input logic [15:0] a, input int n,
                                    output logic [15:0] r, output logic c, output int eff);
    int unsigned x;
    logic signed [15:0] sa;
    x   = a;
    sa  = a;
    eff = (op > 5) ? 0 : n;
    r   = a;
    c   = 1'b0;
    if (eff > 0) begin
      case (op)
        0, 2: begin r = 16'(x << eff); c = a[16-eff]; end
        1:    begin r = 16'(x >> eff); c = a[eff-1]; end
        3:    begin r = sa >>> eff;    c = a[eff-1]; end
        4:    begin r = 16'((x << eff) | (x >> (16 - eff))); c = r[0]; end
        5:    begin r = 16'((x >> eff) | (x << (16 - eff))); c = r[15]; end
        default: ;
      endcase
    end
  endfunction

  function automatic logic [2:0] exp_sh_op(input int op);
    case (op)
      0, 4:    return 3'(SHIFTER_OPERATION_LEFT_LOGICALLY);
      1, 5:    return 3'(SHIFTER_OPERATION_RIGHT_LOGICALLY);
      2:       return 3'(SHIFTER_OPERATION_LEFT_ARITHMETICALLY);
      3:       return 3'(SHIFTER_OPERATION_RIGHT_ARITHMETICALLY);
      default: return 3'(SHIFTER_OPERATION_NOP);
    endcase
  endfunction

  // Present a request and return at the falling edge where it is seen with
  // req_ready high (the following rising edge accepts it).
  task automatic send_req(input int op, input logic [15:0] a, input int cnt);
    int w;
    @(negedge clk);
    req_valid   = 1'b1;
    req_op      = 3'(op);
    req_operand = a;
    req_count   = CW'(cnt);
    w = 0;
    while (!req_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) check_val("accept_timeout", 32'(req_ready), 32'd1);
  endtask

  // Called at the falling edge one cycle after the accepting cycle.
  task automatic collect(input int op, input logic [15:0] a, input int cnt, input int bp);
    logic [15:0] r;
    logic        c;
    int          eff, k, nsh;
    ref_model(op, a, cnt, r, c, eff);
    check_val("sh_in_first", 32'(sh_in), 32'(a));
    k = 1;
    nsh = 0;
    while (!resp_valid && k < 40) begin
      if (sh_operation != SHIFTER_OPERATION_NOP) begin
        nsh++;
        check_val("sh_op", 32'(sh_operation), 32'(exp_sh_op(op)));
      end
      @(negedge clk);
      k++;
    end
    check_val("latency", 32'(k), 32'(eff + 1));
    check_val("step_count", 32'(nsh), 32'(eff));
    check_val("result", 32'(resp_result), 32'(r));
    check_val("carry", 32'(resp_carry), 32'(c));
    check_val("busy_done", 32'(busy), 32'd1);
    check_val("sh_op_done", 32'(sh_operation), 32'(SHIFTER_OPERATION_NOP));
    resp_ready = 1'b0;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check_val("hold_valid", 32'(resp_valid), 32'd1);
      check_val("hold_result", 32'({resp_carry, resp_result}), 32'({c, r}));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_val("post_valid", 32'(resp_valid), 32'd0);
    check_val("post_ready", 32'(req_ready), 32'd1);
    check_val("post_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_req(input int op, input logic [15:0] a, input int cnt, input int bp);
    send_req(op, a, cnt);
    @(negedge clk);
    req_valid = 1'b0;
    collect(op, a, cnt, bp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check_val({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check_val({tag, "_result"}, 32'({resp_carry, resp_result}), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_sh_op"}, 32'(sh_operation), 32'(SHIFTER_OPERATION_NOP));
    check_val({tag, "_sh_cin"}, 32'(sh_cin), 32'd0);
    check_val({tag, "_sh_in"}, 32'(sh_in), 32'd0);
  endtask

  initial begin
    int spurious;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // Directed cases.
    run_req(1, 16'hA5A5, 1, 0);    // SRL
    run_req(0, 16'h00A5, 4, 1);    // SLL
    run_req(4, 16'h8001, 1, 0);    // ROL
    run_req(5, 16'h0123, 4, 2);    // ROR
    run_req(3, 16'h8000, 15, 0);   // SRA, maximum count
    run_req(0, 16'h1234, 0, 0);    // count 0
    run_req(6, 16'hBEEF, 9, 0);    // reserved op
    run_req(2, 16'hC003, 15, 0);   // SLA, maximum count

    // Backpressure with a second request waiting.
    send_req(1, 16'hA5A5, 1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_val("bp_valid", 32'(resp_valid), 32'd1);
    req_valid   = 1'b1;
    req_op      = 3'd4;
    req_operand = 16'h8001;
    req_count   = CW'(1);
    resp_ready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("bp_req_ready", 32'(req_ready), 32'd0);
      check_val("bp_hold", 32'({resp_valid, resp_carry, resp_result}), 32'({1'b1, 1'b1, 16'h52D2}));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_val("bp_release_ready", 32'(req_ready), 32'd1);
    check_val("bp_release_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check_val("bp_second_busy", 32'(busy), 32'd1);
    collect(4, 16'h8001, 1, 0);

    // Asynchronous reset in the middle of a shift.
    send_req(0, 16'h1234, 10);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b1;
    spurious = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (resp_valid || !req_ready) spurious++;
    end
    check_val("no_spurious_resp", 32'(spurious), 32'd0);

    // Randomized requests against the reference model.
    for (int i = 0; i < 40; i++) begin
      run_req(int'($urandom_range(0, 7)), 16'($urandom), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
